// File: rtl/load_extend_pipe.sv
// ---------------------------------------------------------------------------
// load_extend_pipe
//
// Two-stage valid/ready pipeline for the load path. It sits between the
// data-memory read port and register writeback. Each request is a memory
// word, a byte offset, an access size and a sign-mode bit. The block selects
// the addressed byte, halfword or word and sign- or zero-extends it to
// DATA_W. A tag (normally the destination register index) travels with the
// request. Misaligned or reserved-size requests still occupy their slot and
// come out with out_err=1 and out_data=0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready
//   in_data    raw memory word, little-endian byte lanes
//   in_off     byte offset within the word
//   in_size    0=byte, 1=half, 2=word (32 bits max), 3=reserved
//   in_s       1=sign-extend, 0=zero-extend
//   in_tag     passthrough tag
//   out_valid  result valid
//   out_ready  consumer accepts when out_valid && out_ready
//   out_data   extended result
//   out_tag    tag of this result
//   out_err    request was misaligned or used the reserved size
// ---------------------------------------------------------------------------
module load_extend_pipe #(
    parameter  int DATA_W = 32,
    parameter  int TAG_W  = 5,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_s,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    // A "word" access is 32 bits wide, or the whole bus when the bus is
    // narrower than that.
    localparam int WORD_W = (DATA_W < 32) ? DATA_W : 32;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Keep the low fw bits of v; fill the rest with the field MSB when s=1,
    // otherwise with zeros.
    function automatic logic [DATA_W-1:0] extend_field(
        input logic [DATA_W-1:0] v,
        input int                fw,
        input logic              s
    );
        logic [DATA_W-1:0] r;
        logic              msb;
        msb = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == fw - 1) msb = v[i];
        end
        for (int i = 0; i < DATA_W; i++) begin
            if (i < fw) r[i] = v[i];
            else        r[i] = s & msb;
        end
        return r;
    endfunction

    // Error results are forced to zero so that a faulting load never leaks
    // partial memory contents into the register file.
    function automatic logic [DATA_W-1:0] extend_result(
        input logic [DATA_W-1:0] v,
        input logic [1:0]        size,
        input logic              s,
        input logic              err
    );
        logic [DATA_W-1:0] r;
        r = '0;
        if (!err) begin
            case (size)
                SZ_BYTE: r = extend_field(v, 8, s);
                SZ_HALF: r = extend_field(v, 16, s);
                SZ_WORD: r = extend_field(v, WORD_W, s);
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic logic misaligned(
        input logic [1:0]       size,
        input logic [OFF_W-1:0] off
    );
        logic e;
        case (size)
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = off[0];
            SZ_WORD: e = (off != '0);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Handshake: a stage may load when its downstream neighbour is empty or
    // is emptying this cycle. out_ready feeds in_ready combinationally.
    logic adv_p1;
    logic adv_p2;
    logic vld_p1;

    assign adv_p2   = !out_valid || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    // ---- stage 0 -> stage 1: align the addressed field to bit 0 ----------
    logic [DATA_W-1:0] shifted_p0;
    logic              err_p0;

    assign shifted_p0 = in_data >> {in_off, 3'b000};
    assign err_p0     = misaligned(in_size, in_off);

    logic [DATA_W-1:0] data_p1;
    logic [1:0]        size_p1;
    logic              s_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic              err_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            data_p1 <= shifted_p0;
            size_p1 <= in_size;
            s_p1    <= in_s;
            tag_p1  <= in_tag;
            err_p1  <= err_p0;
        end
    end

    // ---- stage 1 -> stage 2: extend and present the result ---------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else if (adv_p2) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_data <= extend_result(data_p1, size_p1, s_p1, err_p1);
                out_tag  <= tag_p1;
                out_err  <= err_p1;
            end
        end
    end

endmodule

// File: tb/tb_load_extend_pipe.sv
module tb_load_extend_pipe;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int OFF_W  = 2;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_off;
    logic [1:0]        in_size;
    logic              in_s;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    load_extend_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_off   (in_off),
        .in_size  (in_size),
        .in_s     (in_s),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .out_err  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  off;
        logic [1:0]  size;
        logic        s;
        logic [4:0]  tag;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    // Independent reference: pick the field by part-select and extend it.
    function automatic logic [32:0] ref_model(input logic [31:0] d, input logic [1:0] off,
                                              input logic [1:0] size, input logic s);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        logic        e;
        e = 1'b0;
        r = 32'h0;
        case (size)
            2'd0: begin
                b = d[off*8 +: 8];
                r = s ? {{24{b[7]}}, b} : {24'h0, b};
            end
            2'd1: begin
                if (off == 2'd0 || off == 2'd2) begin
                    h = d[off*8 +: 16];
                    r = s ? {{16{h[15]}}, h} : {16'h0, h};
                end else e = 1'b1;
            end
            2'd2: begin
                if (off == 2'd0) r = d;
                else e = 1'b1;
            end
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    task automatic drive(input logic [31:0] d, input logic [1:0] off, input logic [1:0] size,
                         input logic s, input logic [4:0] tag);
        in_valid = 1'b1;
        in_data  = d;
        in_off   = off;
        in_size  = size;
        in_s     = s;
        in_tag   = tag;
    endtask

    logic [31:0] st_data [16];
    logic [1:0]  st_off  [16];
    logic [1:0]  st_size [16];
    logic        st_s    [16];
    logic [32:0] st_exp  [16];

    initial begin
        vecs[0]  = '{32'h000000F1, 2'd0, 2'd0, 1'b0, 5'd1,  32'h000000F1, 1'b0};
        vecs[1]  = '{32'h000000F1, 2'd0, 2'd0, 1'b1, 5'd2,  32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{32'h80010000, 2'd2, 2'd1, 1'b1, 5'd3,  32'hFFFF8001, 1'b0};
        vecs[3]  = '{32'h80010000, 2'd2, 2'd1, 1'b0, 5'd4,  32'h00008001, 1'b0};
        vecs[4]  = '{32'h80000009, 2'd0, 2'd2, 1'b1, 5'd5,  32'h80000009, 1'b0};
        vecs[5]  = '{32'h12345678, 2'd1, 2'd1, 1'b1, 5'd26, 32'h00000000, 1'b1};
        vecs[6]  = '{32'h12345678, 2'd2, 2'd2, 1'b0, 5'd27, 32'h00000000, 1'b1};
        vecs[7]  = '{32'hFFFFFFFF, 2'd0, 2'd3, 1'b1, 5'd28, 32'h00000000, 1'b1};
        vecs[8]  = '{32'h8A000000, 2'd3, 2'd0, 1'b1, 5'd9,  32'hFFFFFF8A, 1'b0};
        vecs[9]  = '{32'h8A000000, 2'd3, 2'd0, 1'b0, 5'd10, 32'h0000008A, 1'b0};
        vecs[10] = '{32'h1234ABCD, 2'd0, 2'd1, 1'b1, 5'd11, 32'hFFFFABCD, 1'b0};
        vecs[11] = '{32'h00007F00, 2'd1, 2'd0, 1'b1, 5'd12, 32'h0000007F, 1'b0};
        vecs[12] = '{32'hDEADBEEF, 2'd0, 2'd2, 1'b0, 5'd13, 32'hDEADBEEF, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_off    = '0;
        in_size   = '0;
        in_s      = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        // Table vectors, one at a time, checking the two-cycle latency
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1 drive(vecs[i].data, vecs[i].off, vecs[i].size, vecs[i].s, vecs[i].tag);
            @(negedge clk);
            chk("vec_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            chk("vec_lat1_valid", 64'(out_valid), 64'd0);
            @(posedge clk);
            @(negedge clk);
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_data",  64'(out_data),  64'(vecs[i].exp_data));
            chk("vec_tag",   64'(out_tag),   64'(vecs[i].tag));
            chk("vec_err",   64'(out_err),   64'(vecs[i].exp_err));
        end
        @(posedge clk);
        #1;

        // Backpressure: tags 1,2 absorbed, tag 3 blocked, then drained in order
        out_ready = 1'b0;
        drive(32'h00000001, 2'd0, 2'd0, 1'b0, 5'd1);
        @(negedge clk);
        chk("bp_rdy_t1", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 drive(32'h00000002, 2'd0, 2'd0, 1'b0, 5'd2);
        @(negedge clk);
        chk("bp_rdy_t2", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 drive(32'h00000003, 2'd0, 2'd0, 1'b0, 5'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rdy_full",  64'(in_ready),  64'd0);
            chk("bp_hold_vld",  64'(out_valid), 64'd1);
            chk("bp_hold_tag",  64'(out_tag),   64'd1);
            chk("bp_hold_data", 64'(out_data),  64'd1);
            chk("bp_hold_err",  64'(out_err),   64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1 chk("bp_rdy_rise", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("bp_o1_tag", 64'(out_tag), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            chk("bp_on_vld",  64'(out_valid), 64'd1);
            chk("bp_on_tag",  64'(out_tag),   64'(k));
            chk("bp_on_data", 64'(out_data),  64'(k));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Streaming: 16 random requests, one per cycle
        for (int k = 0; k < 16; k++) begin
            st_data[k] = $urandom;
            st_off[k]  = 2'($urandom_range(0, 3));
            st_size[k] = 2'($urandom_range(0, 3));
            st_s[k]    = 1'($urandom_range(0, 1));
            st_exp[k]  = ref_model(st_data[k], st_off[k], st_size[k], st_s[k]);
        end
        for (int k = 0; k < 18; k++) begin
            @(posedge clk);
            #1;
            if (k < 16) drive(st_data[k], st_off[k], st_size[k], st_s[k], 5'(k));
            else        in_valid = 1'b0;
            @(negedge clk);
            if (k < 16) chk("st_in_ready", 64'(in_ready), 64'd1);
            if (k >= 2) begin
                chk("st_valid", 64'(out_valid), 64'd1);
                chk("st_tag",   64'(out_tag),   64'(k - 2));
                chk("st_data",  64'(out_data),  64'(st_exp[k-2][31:0]));
                chk("st_err",   64'(out_err),   64'(st_exp[k-2][32]));
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("st_end_valid", 64'(out_valid), 64'd0);

        // Reset with two requests in flight
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(32'h00000005, 2'd0, 2'd0, 1'b0, 5'd5);
        @(posedge clk);
        #1 drive(32'h00000006, 2'd0, 2'd0, 1'b0, 5'd6);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("mr_pre_valid", 64'(out_valid), 64'd1);
        chk("mr_pre_rdy",   64'(in_ready),  64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 64'(out_valid), 64'd0);
        chk("mr_async_rdy",   64'(in_ready),  64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mr_no_stale", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        drive(32'h0000B200, 2'd1, 2'd0, 1'b1, 5'd17);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("mr_new_lat1", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mr_new_valid", 64'(out_valid), 64'd1);
        chk("mr_new_data",  64'(out_data),  64'hFFFFFFB2);
        chk("mr_new_tag",   64'(out_tag),   64'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
